// File: rtl/ram_dp_ctrl_pkg.sv
// rtl/ram_dp_ctrl_pkg.sv - shared types for the dual-port RAM controller
package ram_dp_ctrl_pkg;

  // Request fields are sized for the widest supported instance; narrower ones zero-extend.
  localparam int AW_MAX = 32;
  localparam int DW_MAX = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [AW_MAX-1:0] addr;
    logic [DW_MAX-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_dp_hazard.sv
// rtl/ram_dp_hazard.sv - same-address collision and priority resolution
module ram_dp_hazard
  import ram_dp_ctrl_pkg::*;
(
  input  req_t r0,
  input  req_t r1,
  input  logic prio,
  output logic gnt0,
  output logic gnt1,
  output logic blocked
);

  logic same;
  logic blk0;
  logic blk1;
  logic unused_wdata;

  assign same = r0.req & r1.req & (r0.addr == r1.addr);

  // A writer always beats a reader; two writers are settled by prio (1 favours client 1).
  assign blk0 = same & ((r1.we & ~r0.we) | (r0.we & r1.we & prio));
  assign blk1 = same & ((r0.we & ~r1.we) | (r0.we & r1.we & ~prio));

  assign gnt0    = r0.req & ~blk0;
  assign gnt1    = r1.req & ~blk1;
  assign blocked = blk0 | blk1;

  assign unused_wdata = ^{r0.wdata, r1.wdata};

endmodule

// File: rtl/ram_dp_ctrl.sv
// rtl/ram_dp_ctrl.sv - zero-fill sequencer and two-client front end for a dual-port RAM
module ram_dp_ctrl
  import ram_dp_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          init_done,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_gnt,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_gnt,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic          ram_w_a,
  output logic [AW-1:0] ram_a_a,
  output logic [DW-1:0] ram_d_a,
  input  logic [DW-1:0] ram_q_a,
  output logic          ram_w_b,
  output logic [AW-1:0] ram_a_b,
  output logic [DW-1:0] ram_d_b,
  input  logic [DW-1:0] ram_q_b
);

  localparam logic [AW-1:0] K_LAST = AW'((2 ** (AW - 1)) - 1);

  state_t        state;
  logic [AW-1:0] fill_k;
  logic          prio;
  logic          rv0, rv1;
  logic [AW-1:0] hold_a_a, hold_a_b;
  logic [DW-1:0] hold_d_a, hold_d_b;

  req_t          r0, r1;
  logic          h_gnt0, h_gnt1, h_blk;
  logic          run, g0, g1;
  logic          w_a, w_b;
  logic [AW-1:0] nxt_a_a, nxt_a_b;
  logic [DW-1:0] nxt_d_a, nxt_d_b;

  assign r0 = '{req: c0_req, we: c0_we, addr: AW_MAX'(c0_addr), wdata: DW_MAX'(c0_wdata)};
  assign r1 = '{req: c1_req, we: c1_we, addr: AW_MAX'(c1_addr), wdata: DW_MAX'(c1_wdata)};

  ram_dp_hazard u_hazard (
    .r0      (r0),
    .r1      (r1),
    .prio    (prio),
    .gnt0    (h_gnt0),
    .gnt1    (h_gnt1),
    .blocked (h_blk)
  );

  assign run = (state == ST_RUN);
  assign g0  = run & h_gnt0;
  assign g1  = run & h_gnt1;

  // Ports keep their last address/data when idle, so the hold registers track whatever was driven.
  always_comb begin
    w_a     = 1'b0;
    w_b     = 1'b0;
    nxt_a_a = hold_a_a;
    nxt_a_b = hold_a_b;
    nxt_d_a = hold_d_a;
    nxt_d_b = hold_d_b;
    if (!run) begin
      w_a     = 1'b1;
      w_b     = 1'b1;
      nxt_a_a = fill_k << 1;
      nxt_a_b = (fill_k << 1) | AW'(1);
      nxt_d_a = '0;
      nxt_d_b = '0;
    end else begin
      if (g0) begin
        w_a     = c0_we;
        nxt_a_a = c0_addr;
        nxt_d_a = c0_wdata;
      end
      if (g1) begin
        w_b     = c1_we;
        nxt_a_b = c1_addr;
        nxt_d_b = c1_wdata;
      end
    end
  end

  // rst_n gates the RAM-side outputs so nothing reaches the RAM while reset is held.
  assign ram_w_a = rst_n & w_a;
  assign ram_w_b = rst_n & w_b;
  assign ram_a_a = rst_n ? nxt_a_a : '0;
  assign ram_a_b = rst_n ? nxt_a_b : '0;
  assign ram_d_a = rst_n ? nxt_d_a : '0;
  assign ram_d_b = rst_n ? nxt_d_b : '0;

  assign init_done = run;
  assign c0_gnt    = g0;
  assign c1_gnt    = g1;
  assign c0_rvalid = rv0;
  assign c1_rvalid = rv1;
  assign c0_rdata  = rv0 ? ram_q_a : '0;
  assign c1_rdata  = rv1 ? ram_q_b : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      fill_k   <= '0;
      prio     <= 1'b0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
      hold_a_a <= '0;
      hold_a_b <= '0;
      hold_d_a <= '0;
      hold_d_b <= '0;
    end else begin
      hold_a_a <= nxt_a_a;
      hold_a_b <= nxt_a_b;
      hold_d_a <= nxt_d_a;
      hold_d_b <= nxt_d_b;
      rv0      <= g0 & ~c0_we;
      rv1      <= g1 & ~c1_we;
      case (state)
        ST_INIT: begin
          if (fill_k == K_LAST) begin
            fill_k <= '0;
            state  <= ST_RUN;
          end else begin
            fill_k <= fill_k + AW'(1);
          end
        end
        ST_RUN: begin
          if (h_blk) prio <= ~prio;
          if (init_req) state <= ST_INIT;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_ctrl.sv
// tb/tb_ram_dp_ctrl.sv - directed self-checking bench for ram_dp_ctrl (AW=4, DW=16)
module tb_ram_dp_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          init_req;
  logic          init_done;
  logic          c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic          c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic          ram_w_a, ram_w_b;
  logic [AW-1:0] ram_a_a, ram_a_b;
  logic [DW-1:0] ram_d_a, ram_d_b, ram_q_a, ram_q_b;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [2**AW] = '{default: 16'hDEAD};

  ram_dp_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_done (init_done),
    .c0_req    (c0_req),
    .c0_we     (c0_we),
    .c0_addr   (c0_addr),
    .c0_wdata  (c0_wdata),
    .c0_gnt    (c0_gnt),
    .c0_rvalid (c0_rvalid),
    .c0_rdata  (c0_rdata),
    .c1_req    (c1_req),
    .c1_we     (c1_we),
    .c1_addr   (c1_addr),
    .c1_wdata  (c1_wdata),
    .c1_gnt    (c1_gnt),
    .c1_rvalid (c1_rvalid),
    .c1_rdata  (c1_rdata),
    .ram_w_a   (ram_w_a),
    .ram_a_a   (ram_a_a),
    .ram_d_a   (ram_d_a),
    .ram_q_a   (ram_q_a),
    .ram_w_b   (ram_w_b),
    .ram_a_b   (ram_a_b),
    .ram_d_b   (ram_d_b),
    .ram_q_b   (ram_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_a) mem[ram_a_a] <= ram_d_a;
    if (ram_w_b) mem[ram_a_b] <= ram_d_b;
    ram_q_a <= mem[ram_a_a];
    ram_q_b <= mem[ram_a_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c0_req = req; c0_we = we; c0_addr = a; c0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c1_req = req; c1_we = we; c1_addr = a; c1_wdata = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_gnt"}, 32'({c0_gnt, c1_gnt}), 32'd0);
    chk({tag, "_rvalid"}, 32'({c0_rvalid, c1_rvalid}), 32'd0);
    chk({tag, "_ram_w"}, 32'({ram_w_a, ram_w_b}), 32'd0);
    chk({tag, "_ram_a"}, 32'({ram_a_a, ram_a_b}), 32'd0);
    chk({tag, "_ram_d"}, {ram_d_a, ram_d_b}, 32'd0);
    chk({tag, "_rdata"}, {c0_rdata, c1_rdata}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    init_req = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    repeat (2) next_cycle();
    chk_all_zero("reset");

    // Zero-fill after release; c0 requests throughout and must never be granted.
    rst_n = 1'b1;
    drive0(1'b1, 1'b0, 4'd3, '0);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill%0d_done", i), 32'(init_done), 32'd0);
      chk($sformatf("fill%0d_gnt", i), 32'(c0_gnt), 32'd0);
      chk($sformatf("fill%0d_w", i), 32'({ram_w_a, ram_w_b}), 32'b11);
      chk($sformatf("fill%0d_a_a", i), 32'(ram_a_a), 32'(2 * i));
      chk($sformatf("fill%0d_a_b", i), 32'(ram_a_b), 32'(2 * i + 1));
      chk($sformatf("fill%0d_d", i), {ram_d_a, ram_d_b}, 32'd0);
      if (i == 7) drive0(1'b0, 1'b0, '0, '0);
      next_cycle();
    end
    chk("fill_end_done", 32'(init_done), 32'd1);

    // Read back every address on both ports, back-to-back.
    for (int i = 0; i < 16; i++) begin
      drive0(1'b1, 1'b0, 4'(i), '0);
      drive1(1'b1, 1'b0, 4'(15 - i), '0);
      #1;
      chk($sformatf("rd%0d_gnt", i), 32'({c0_gnt, c1_gnt}), 32'b11);
      next_cycle();
      chk($sformatf("rd%0d_rv", i), 32'({c0_rvalid, c1_rvalid}), 32'b11);
      chk($sformatf("rd%0d_data", i), {c0_rdata, c1_rdata}, 32'd0);
    end
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();

    // c0 writes 3, c1 reads it back next cycle.
    drive0(1'b1, 1'b1, 4'd3, 16'hABCD);
    #1;
    chk("wr3_gnt", 32'(c0_gnt), 32'd1);
    chk("wr3_port", {ram_w_a, 3'b0, ram_a_a, ram_d_a}, {4'b1000, 4'd3, 16'hABCD, 8'h0} >> 8);
    next_cycle();
    chk("wr3_rv", 32'(c0_rvalid), 32'd0);
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b0, 4'd3, '0);
    #1;
    chk("rd3_gnt", 32'(c1_gnt), 32'd1);
    chk("rd3_hold_a", 32'({ram_w_a, ram_a_a}), 32'h03);
    next_cycle();
    chk("rd3_rv", 32'(c1_rvalid), 32'd1);
    chk("rd3_data", 32'(c1_rdata), 32'hABCD);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();

    // Write/write collision on 5 held three cycles: grants alternate c0, c1, c0.
    drive0(1'b1, 1'b1, 4'd5, 16'h1111);
    drive1(1'b1, 1'b1, 4'd5, 16'h2222);
    #1;
    chk("ww_c1", 32'({c0_gnt, c1_gnt}), 32'b10);
    next_cycle();
    chk("ww_c2", 32'({c0_gnt, c1_gnt}), 32'b01);
    next_cycle();
    chk("ww_c3", 32'({c0_gnt, c1_gnt}), 32'b10);
    next_cycle();
    drive0(1'b1, 1'b0, 4'd5, '0);
    drive1(1'b0, 1'b0, '0, '0);
    #1;
    chk("ww_rd_gnt", 32'(c0_gnt), 32'd1);
    next_cycle();
    chk("ww_rd_data", 32'({c0_rvalid, c0_rdata}), 32'h1_1111);

    // Read/write collision on 7: writer first, reader sees the new value.
    drive0(1'b1, 1'b0, 4'd7, '0);
    drive1(1'b1, 1'b1, 4'd7, 16'h7777);
    #1;
    chk("rw_gnt", 32'({c0_gnt, c1_gnt}), 32'b01);
    next_cycle();
    drive1(1'b0, 1'b0, '0, '0);
    #1;
    chk("rw_c0_gnt", 32'(c0_gnt), 32'd1);
    chk("rw_c0_norv", 32'(c0_rvalid), 32'd0);
    next_cycle();
    chk("rw_c0_data", 32'({c0_rvalid, c0_rdata}), 32'h1_7777);

    // Both read 2 together.
    drive0(1'b1, 1'b0, 4'd2, '0);
    drive1(1'b1, 1'b0, 4'd2, '0);
    #1;
    chk("rr_gnt", 32'({c0_gnt, c1_gnt}), 32'b11);
    next_cycle();
    chk("rr_rv", 32'({c0_rvalid, c1_rvalid}), 32'b11);
    chk("rr_data", {c0_rdata, c1_rdata}, 32'd0);
    drive0(1'b0, 1'b0, '0, '0);

    // init_req during a c1 read stream.
    drive1(1'b1, 1'b0, 4'd3, '0);
    #1;
    chk("ir_gnt0", 32'(c1_gnt), 32'd1);
    next_cycle();
    chk("ir_data0", 32'({c1_rvalid, c1_rdata}), 32'h1_ABCD);
    drive1(1'b1, 1'b0, 4'd7, '0);
    init_req = 1'b1;
    #1;
    chk("ir_last_gnt", 32'({init_done, c1_gnt}), 32'b11);
    next_cycle();
    init_req = 1'b0;
    drive1(1'b1, 1'b0, 4'd3, '0);
    #1;
    chk("ir_last_data", 32'({c1_rvalid, c1_rdata}), 32'h1_7777);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("ir_init%0d", j), 32'({init_done, c1_gnt}), 32'b00);
      if (j > 0) chk($sformatf("ir_init%0d_rv", j), 32'(c1_rvalid), 32'd0);
      next_cycle();
    end
    chk("ir_back", 32'({init_done, c1_gnt}), 32'b11);
    next_cycle();
    chk("ir_refill", 32'({c1_rvalid, c1_rdata}), 32'h1_0000);
    drive1(1'b0, 1'b0, '0, '0);

    // Reset with a read in flight drops its rvalid.
    drive0(1'b1, 1'b0, 4'd2, '0);
    #1;
    chk("rst_rd_gnt", 32'(c0_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_run");
    next_cycle();
    chk("rst_rv_drop", 32'(c0_rvalid), 32'd0);
    drive0(1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    next_cycle();

    // Reset mid-fill restarts the fill at 0/1.
    chk("mid_k1", 32'({ram_a_a, ram_a_b}), 32'h23);
    next_cycle();
    chk("mid_k2", 32'({ram_a_a, ram_a_b}), 32'h45);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_init");
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("restart_k0", 32'({ram_w_a, ram_w_b, ram_a_a, ram_a_b}), 32'h301);
    next_cycle();
    chk("restart_k1", 32'({ram_a_a, ram_a_b}), 32'h23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_dp_ctrl.md
Name: ram_dp_ctrl

Overview:
- Controller that sits between two client request channels and one dual-port synchronous RAM (port A, port B).
- After reset, or on request, it sequences a zero-fill of the whole RAM, then maps client 0 to port A and client 1 to port B.
- Resolves same-address hazards between the two ports with a fairness-rotating priority.
- Returns read data with a fixed one-cycle latency and a valid strobe.

Parameters:
AW, 16, address width; RAM depth is 2**AW; AW >= 1.
DW, 16, data width.

Ports:
clk  input  1  single clock; the RAM's clk_a and clk_b are tied to it at the top level.
rst_n  input  1  asynchronous active-low reset.
init_req  input  1  one-cycle pulse; restarts the zero-fill while in RUN.
init_done  output  1  high while in RUN.
c0_req  input  1  client 0 request valid.
c0_we  input  1  client 0 write (1) / read (0).
c0_addr  input  AW  client 0 address.
c0_wdata  input  DW  client 0 write data.
c0_gnt  output  1  client 0 request accepted this cycle.
c0_rvalid  output  1  client 0 read data valid.
c0_rdata  output  DW  client 0 read data.
c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as client 0, for client 1.
ram_w_a  output  1  port A write enable.
ram_a_a  output  AW  port A address.
ram_d_a  output  DW  port A write data.
ram_q_a  input  DW  port A read data, valid one cycle after address.
ram_w_b, ram_a_b, ram_d_b, ram_q_b: same as port A, for port B.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- FSM states: INIT, RUN. Reset state is INIT.
- Values while rst_n low:
  - fill counter = 0, prio = 0.
  - init_done, all gnt, all rvalid, ram_w_a, ram_w_b = 0.
  - ram addresses, ram data, rdata = 0.
- Outputs are combinational from the registered state and the inputs.
- INIT:
  - Each cycle: port A writes 0 to address 2k, port B writes 0 to address 2k+1, where k is the fill counter.
  - k runs 0 .. 2**(AW-1)-1. After the last pair, next state is RUN and k returns to 0.
  - The fill takes exactly 2**(AW-1) cycles.
  - c0_gnt = c1_gnt = 0 throughout. init_req is ignored.
- RUN:
  - init_done = 1.
  - init_req = 1 moves to INIT next cycle. Requests are still served in the cycle init_req is sampled.
  - A client request is granted only when no hazard blocks it: gnt = req & ~blocked.
  - Granted client 0 drives port A; granted client 1 drives port B. w = we.
  - When a port is not granted: w = 0, address and data hold their previous values.
- Hazard: c0_req & c1_req & (c0_addr == c1_addr).
  - Both reads: no block; both granted.
  - Both writes: the winner is client prio; the other is blocked.
  - One write, one read: the writer is granted and the reader is blocked. This avoids read-during-write ambiguity.
  - prio toggles on every cycle in which a client is blocked. It is otherwise unchanged.
- A blocked client must hold req, we, addr and wdata until it is granted. The controller does not queue requests.
- Read response:
  - Granted read in cycle t gives cN_rvalid = 1 in cycle t+1, with cN_rdata = ram_q of that client's port.
  - Back-to-back reads give back-to-back rvalid.
  - A read granted in the final RUN cycle still returns rvalid in the first INIT cycle.
- Reset asserted mid-fill or mid-read: the fill aborts and pending rvalid is dropped. The fill restarts from k = 0 after release.

Decomposition:
- Package ram_dp_ctrl_pkg holds:
  - state enum (ST_INIT, ST_RUN);
  - a request struct {req, we, addr, wdata}.
- Sub-module ram_dp_hazard: combinational collision and priority resolution. Inputs: both requests, prio. Outputs: gnt0, gnt1, blocked.
- The FSM, fill counter, prio register and rvalid pipeline stay in ram_dp_ctrl.

Test Plan:
- Reset release, AW = 4:
  - INIT lasts 8 cycles; port A writes 0 to 0, 2, .., 14 and port B to 1, 3, .., 15, both with w = 1.
  - init_done rises in cycle 9.
  - A read of every address afterwards returns 0.
- RUN, c0 writes 0xABCD to 3, then c1 reads 3 the next cycle: c1_rvalid one cycle after grant, with c1_rdata = 0xABCD.
- c0 and c1 both write address 5, held for 3 cycles:
  - grants go c0, c1, c0 (prio toggles);
  - a final read of address 5 returns the last granted write's data.
- c0 reads and c1 writes address 7 in the same cycle:
  - c1 is granted and c0 is blocked;
  - next cycle c0 is granted and its rdata shows the new value.
- Both clients read address 2 simultaneously: both granted, and both rvalid are set in the same following cycle.
- init_req while c1 is streaming reads:
  - the last granted read still gets rvalid;
  - grants drop to 0 for 8 cycles and init_done = 0, then return.
  - Assert rst_n low mid-INIT: all outputs go 0 and the fill restarts from address 0/1.
